// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider #(
    parameter int unsigned Size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [Size-1:0] A,
    input  logic [Size-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [Size-1:0] Q,
    output logic [Size-1:0] R,
    output logic            div_zero
);

    localparam int unsigned CntW = $clog2(Size + 1);
    localparam int unsigned RemW = Size + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RemW-1:0]     rem_q, rem_d;
    logic [Size-1:0]     quo_q, quo_d;
    logic [Size-1:0]     dvs_q, dvs_d;
    logic [Size-1:0]     q_q, q_d;
    logic [Size-1:0]     r_q, r_d;
    logic                dz_q, dz_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RemW-1:0]     rem_sh;
    logic [RemW-1:0]     diff;
    logic [Size-1:0]     a_mag;
    logic [Size-1:0]     b_mag;
    logic [Size-1:0]     q_res;
    logic [Size-1:0]     r_res;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    // Magnitude of a two's-complement value; the most-negative value maps to itself,
    // which is still correct when read as unsigned.
    function automatic logic [Size-1:0] mag(input logic [Size-1:0] x);
        return x[Size-1] ? (Size'(0) - x) : x;
    endfunction

    always_comb begin
        a_mag = mag(A);
        b_mag = mag(B);
        q_res = neg_q_q ? (Size'(0) - quo_q) : quo_q;
        r_res = neg_r_q ? (Size'(0) - rem_q[Size-1:0]) : rem_q[Size-1:0];
    end
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
        q_res = quo_q;
        r_res = rem_q[Size-1:0];
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    // Next-state, trial subtraction and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef DIVIDER_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        rem_sh  = (rem_q << 1) | RemW'(quo_q[Size-1]);
        diff    = rem_sh - {1'b0, dvs_q};

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (B == '0) begin
                        state_d = ST_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = CntW'(Size);
`ifdef DIVIDER_SIGNED_EN
                        neg_q_d = A[Size-1] ^ B[Size-1];
                        neg_r_d = A[Size-1];
`endif
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    // Results are only published on entry to DONE.
                    state_d = ST_DONE;
                    q_d     = q_res;
                    r_d     = r_res;
                    dz_d    = 1'b0;
                end else begin
                    if (!diff[Size]) begin
                        rem_d = diff;
                        quo_d = {quo_q[Size-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        quo_d = {quo_q[Size-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (unsigned build, Size=8) with a result scoreboard.
module tb_seq_divider;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] q_out;
    logic [W-1:0] r_out;
    logic         div_zero;

    exp_t sb[$];
    int   evals = 0;
    int   fails = 0;

    seq_divider #(.Size(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .busy     (busy),
        .done     (done),
        .Q        (q_out),
        .R        (r_out),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge; leaves the bench at #1 after the start edge.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        if (push) begin
            if (b == '0) begin
                e.q = '1; e.r = a; e.dz = 1'b1;
            end else begin
                e.q = a / b; e.r = a % b; e.dz = 1'b0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, check its latency, then pop and compare the result.
    task automatic wait_done(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        if (done === 1'b1) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_Q"}, 32'(q_out), 32'(e.q));
                chk({tag, "_R"}, 32'(r_out), 32'(e.r));
                chk({tag, "_dz"}, 32'(div_zero), 32'(e.dz));
            end else begin
                chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            end
        end
    endtask

    // Watch for a stray done over a number of cycles.
    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_Q", 32'(q_out), 32'd0);
        chk("rst_R", 32'(r_out), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 100/7: busy during iteration, done 9 edges after start, one-cycle pulse
        do_start(8'd100, 8'd7, 1'b1);
        chk("d100_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("d100_Q_held", 32'(q_out), 32'd0);
        wait_done("d100", 8);
        @(posedge clk);
        #1;
        chk("d100_done_pulse", 32'(done), 32'd0);
        chk("d100_idle_busy", 32'(busy), 32'd0);

        // 255/1, then back-to-back 5/9 started in the done cycle
        @(negedge clk);
        do_start(8'd255, 8'd1, 1'b1);
        wait_done("d255", 9);
        do_start(8'd5, 8'd9, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_Q_held", 32'(q_out), 32'd255);
        wait_done("d5", 9);

        // Divide by zero, then a normal divide clears div_zero
        @(negedge clk);
        do_start(8'd37, 8'd0, 1'b1);
        wait_done("dz37", 0);
        @(negedge clk);
        do_start(8'd20, 8'd4, 1'b1);
        chk("d20_Q_held", 32'(q_out), 32'hFF);
        chk("d20_dz_held", 32'(div_zero), 32'd1);
        wait_done("d20", 9);

        // Start while busy is ignored
        @(negedge clk);
        do_start(8'd100, 8'd7, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'd9;
        b_in  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign", 6);
        no_done("ign_no_second", 12);

        // Reset mid-run aborts without a done pulse
        @(negedge clk);
        do_start(8'd100, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_Q", 32'(q_out), 32'd0);
        chk("abort_R", 32'(r_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        no_done("abort_no_done", 12);
        @(negedge clk);
        do_start(8'd50, 8'd6, 1'b1);
        wait_done("d50", 9);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
